// File: rtl/aes_sys_pkg.sv
// Shared definitions for the AES block-to-memory writer: default widths,
// words per AES block, and the writer FSM state type.
package aes_sys_pkg;

    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_CNT_W   = 13;
    localparam int BLOCK_WORDS = 4;
    localparam int IDX_W       = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/aes_blk_serializer.sv
// Holds one captured 128-bit AES block and presents it as 32-bit words,
// most significant word first as the word index counts up.
module aes_blk_serializer
    import aes_sys_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [127:0]       blk_data,
    input  logic [IDX_W-1:0]   word_idx,
    output logic [31:0]        word
);

    logic [127:0] hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (load) begin
            hold <= blk_data;
        end
    end

    always_comb begin
        word = hold[127:96];
        case (word_idx)
            2'd0:    word = hold[127:96];
            2'd1:    word = hold[95:64];
            2'd2:    word = hold[63:32];
            2'd3:    word = hold[31:0];
            default: word = hold[127:96];
        endcase
    end

endmodule

// File: rtl/aes_block_mem_writer.sv
// Accepts AES output blocks over a valid/ready handshake and writes each
// one as four consecutive 32-bit words into an on-chip memory.
module aes_block_mem_writer
    import aes_sys_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [127:0]      blk_data,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blocks_written
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pointer;
    logic [CNT_W-1:0]  remaining;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       ser_word;
    logic              last_word;
    logic              handshake;

    assign last_word = (word_idx == IDX_W'(BLOCK_WORDS - 1));
    assign handshake = (state == LOAD) && blk_valid;

    aes_blk_serializer u_serializer (
        .clk      (clk),
        .reset    (reset),
        .load     (handshake),
        .blk_data (blk_data),
        .word_idx (word_idx),
        .word     (ser_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        blk_ready      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        mem_write      = 1'b0;
        mem_chipselect = 1'b0;
        mem_byteenable = 4'h0;
        mem_writedata  = 32'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_blocks == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                blk_ready = 1'b1;
                busy      = 1'b1;
                if (blk_valid) begin
                    next_state = WR;
                end
            end
            WR: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                mem_chipselect = 1'b1;
                mem_byteenable = 4'hF;
                mem_writedata  = ser_word;
                if (last_word) begin
                    next_state = (remaining != CNT_W'(1)) ? LOAD : DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointer and block counters; a start outside IDLE never reaches here.
    always_ff @(posedge clk) begin
        if (reset) begin
            pointer        <= '0;
            remaining      <= '0;
            word_idx       <= '0;
            blocks_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pointer        <= base_addr;
                        remaining      <= num_blocks;
                        blocks_written <= '0;
                    end
                end
                LOAD: begin
                    if (blk_valid) begin
                        word_idx <= '0;
                    end
                end
                WR: begin
                    pointer  <= pointer + ADDR_W'(1);
                    word_idx <= word_idx + IDX_W'(1);
                    if (last_word) begin
                        blocks_written <= blocks_written + CNT_W'(1);
                        remaining      <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_address = pointer;
    assign mem_clken   = 1'b1;

endmodule

// File: tb/tb_aes_block_mem_writer.sv
// Randomized self-checking bench: a monitor records writes, handshakes and
// done pulses; each test compares them against an address/data model.
module tb_aes_block_mem_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [14:0]  base_addr;
    logic [12:0]  num_blocks;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [14:0]  mem_address;
    logic [3:0]   mem_byteenable;
    logic         mem_chipselect;
    logic         mem_write;
    logic [31:0]  mem_writedata;
    logic         mem_clken;
    logic         busy;
    logic         done;
    logic [12:0]  blocks_written;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [14:0]  wa_q[$];
    logic [31:0]  wd_q[$];
    int           wc_q[$];
    int           hs_q[$];
    logic [14:0]  exp_a[$];
    logic [31:0]  exp_d[$];
    logic [127:0] blks[16];
    int           done_cnt;
    int           done_cyc;
    int           busy_seen;
    int           viol;

    aes_block_mem_writer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_blocks     (num_blocks),
        .blk_data       (blk_data),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .blocks_written (blocks_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs activity and counts bus-rule violations.
    always @(negedge clk) begin
        if (mem_clken !== 1'b1) viol++;
        if (mem_write === 1'b1) begin
            if (mem_chipselect !== 1'b1 || mem_byteenable !== 4'hF) viol++;
            wa_q.push_back(mem_address);
            wd_q.push_back(mem_writedata);
            wc_q.push_back(cyc);
        end else if (mem_write !== 1'b0 || mem_chipselect !== 1'b0 ||
                     mem_byteenable !== 4'h0 || mem_writedata !== 32'h0) begin
            viol++;
        end
        if (blk_ready === 1'b1 && (mem_write === 1'b1 || busy !== 1'b1)) viol++;
        if (busy === 1'b1 && done === 1'b1) viol++;
        if (blk_valid === 1'b1 && blk_ready === 1'b1) hs_q.push_back(cyc);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen++;
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        hs_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_seen = 0;
        viol      = 0;
    endtask

    // Reference model: block b, word w lands at base+4b+w (mod 2^15), MSW first.
    function automatic void build_exp(input logic [14:0] base, input int n);
        exp_a.delete();
        exp_d.delete();
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 4; w++) begin
                exp_a.push_back(base + 15'(4 * b + w));
                exp_d.push_back(blks[b][127 - 32 * w -: 32]);
            end
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [14:0] b, input logic [12:0] n, output int sc);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = b;
        num_blocks = n;
        @(negedge clk);
        sc = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = 15'($urandom);
        num_blocks = 13'($urandom);
    endtask

    task automatic feed(input int n, input bit rnd, input bit poke_start);
        int guard;
        for (int b = 0; b < n; b++) begin
            guard = 0;
            forever begin
                blk_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                blk_data  = blk_valid ? blks[b] : rand128();
                @(negedge clk);
                if (blk_valid && blk_ready) break;
                guard++;
                if (guard > 200) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL feed_timeout block=%0d got=no_handshake exp=handshake", b);
                    blk_valid = 1'b0;
                    return;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            blk_valid = 1'b0;
            blk_data  = rand128();
            if (poke_start && b == 0) begin
                start      = 1'b1;
                base_addr  = 15'h1234;
                num_blocks = 13'd7;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (mem_address !== 15'h0) begin bad++; $display("[TB] FAIL rst_addr got=%h exp=0", mem_address); end
        total++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr got=%b%b exp=00", mem_write, mem_chipselect); end
        total++; if (mem_byteenable !== 4'h0 || mem_writedata !== 32'h0) begin bad++; $display("[TB] FAIL rst_data got=%h/%h exp=0/0", mem_byteenable, mem_writedata); end
        total++; if (mem_clken !== 1'b1) begin bad++; $display("[TB] FAIL rst_clken got=%b exp=1", mem_clken); end
        total++; if (blk_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL rst_ctrl got=%b%b%b exp=000", blk_ready, busy, done); end
        total++; if (blocks_written !== 13'h0) begin bad++; $display("[TB] FAIL rst_bw got=%0d exp=0", blocks_written); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int sc;
        clear_mon();
        blks[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        build_exp(15'h0010, 1);
        do_start(15'h0010, 13'd1, sc);
        feed(1, 1'b0, 1'b0);
        wait_done();
        total++; if (wa_q.size() != 4) begin bad++; $display("[TB] FAIL single_count got=%0d exp=4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("[TB] FAIL single_word%0d got=%h@%h exp=%h@%h", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
            end
        end
        if (hs_q.size() == 1 && wc_q.size() == 4) begin
            total++;
            if (wc_q[0] != hs_q[0] + 1 || wc_q[3] != hs_q[0] + 4) begin
                bad++;
                $display("[TB] FAIL single_latency got=%0d..%0d exp=%0d..%0d", wc_q[0], wc_q[3], hs_q[0] + 1, hs_q[0] + 4);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL single_done got=%0d exp=1", done_cnt); end
        total++; if (blocks_written !== 13'd1) begin bad++; $display("[TB] FAIL single_bw got=%0d exp=1", blocks_written); end
        total++; if (viol != 0) begin bad++; $display("[TB] FAIL single_bus got=%0d exp=0", viol); end
        repeat (5) @(negedge clk);
        total++; if (blocks_written !== 13'd1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL single_hold got=%0d/%b exp=1/0", blocks_written, busy); end
    endtask

    task automatic test_wrap();
        int sc;
        clear_mon();
        blks[0] = rand128();
        blks[1] = rand128();
        build_exp(15'h7FFE, 2);
        do_start(15'h7FFE, 13'd2, sc);
        feed(2, 1'b1, 1'b0);
        wait_done();
        total++; if (wa_q.size() != 8) begin bad++; $display("[TB] FAIL wrap_count got=%0d exp=8", wa_q.size()); end
        for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("[TB] FAIL wrap_word%0d got=%h@%h exp=%h@%h", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
            end
        end
        total++; if (blocks_written !== 13'd2 || done_cnt != 1) begin bad++; $display("[TB] FAIL wrap_bw got=%0d/%0d exp=2/1", blocks_written, done_cnt); end
    endtask

    task automatic test_zero();
        int sc;
        clear_mon();
        do_start(15'($urandom), 13'd0, sc);
        wait_done();
        total++; if (wa_q.size() != 0) begin bad++; $display("[TB] FAIL zero_writes got=%0d exp=0", wa_q.size()); end
        total++; if (done_cnt != 1 || done_cyc != sc + 1) begin bad++; $display("[TB] FAIL zero_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, sc + 1); end
        total++; if (busy_seen != 0) begin bad++; $display("[TB] FAIL zero_busy got=%0d exp=0", busy_seen); end
        total++; if (blocks_written !== 13'd0) begin bad++; $display("[TB] FAIL zero_bw got=%0d exp=0", blocks_written); end
    endtask

    task automatic test_backpressure();
        int sc;
        logic [14:0] base;
        clear_mon();
        base = 15'($urandom);
        for (int b = 0; b < 3; b++) blks[b] = rand128();
        build_exp(base, 3);
        do_start(base, 13'd3, sc);
        feed(3, 1'b1, 1'b1);
        wait_done();
        total++; if (wa_q.size() != 12) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=12", wa_q.size()); end
        for (int i = 0; i < 12 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("[TB] FAIL bp_word%0d got=%h@%h exp=%h@%h", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
            end
        end
        total++; if (blocks_written !== 13'd3 || done_cnt != 1) begin bad++; $display("[TB] FAIL bp_bw got=%0d/%0d exp=3/1", blocks_written, done_cnt); end
        total++; if (hs_q.size() != 3 || viol != 0) begin bad++; $display("[TB] FAIL bp_hs got=%0d/%0d exp=3/0", hs_q.size(), viol); end
    endtask

    task automatic test_back_to_back();
        int sc;
        logic [14:0] base;
        clear_mon();
        base = 15'($urandom);
        for (int b = 0; b < 4; b++) blks[b] = rand128();
        build_exp(base, 4);
        do_start(base, 13'd4, sc);
        feed(4, 1'b0, 1'b0);
        wait_done();
        total++; if (hs_q.size() != 4) begin bad++; $display("[TB] FAIL b2b_hs got=%0d exp=4", hs_q.size()); end
        for (int i = 1; i < hs_q.size(); i++) begin
            total++;
            if (hs_q[i] - hs_q[i-1] != 5) begin bad++; $display("[TB] FAIL b2b_gap%0d got=%0d exp=5", i, hs_q[i] - hs_q[i-1]); end
        end
        total++; if (wa_q.size() != 16) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=16", wa_q.size()); end
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("[TB] FAIL b2b_word%0d got=%h@%h exp=%h@%h", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
            end
        end
        total++; if (blocks_written !== 13'd4) begin bad++; $display("[TB] FAIL b2b_bw got=%0d exp=4", blocks_written); end
    endtask

    task automatic test_reset_mid();
        int sc;
        int guard;
        logic [14:0] base;
        clear_mon();
        for (int b = 0; b < 2; b++) blks[b] = rand128();
        do_start(15'($urandom), 13'd2, sc);
        blk_valid = 1'b1;
        blk_data  = blks[0];
        guard = 0;
        @(negedge clk);
        while (!blk_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0 || mem_address !== 15'h0) begin bad++; $display("[TB] FAIL mid_rst_mem got=%b%b/%h exp=00/0", mem_write, mem_chipselect, mem_address); end
        total++; if (busy !== 1'b0 || blk_ready !== 1'b0 || done !== 1'b0 || blocks_written !== 13'd0) begin bad++; $display("[TB] FAIL mid_rst_ctrl got=%b%b%b/%0d exp=000/0", busy, blk_ready, done, blocks_written); end
        repeat (10) @(negedge clk);
        total++; if (wa_q.size() != 2 || done_cnt != 0) begin bad++; $display("[TB] FAIL mid_abort got=%0d/%0d exp=2/0", wa_q.size(), done_cnt); end

        clear_mon();
        base    = 15'($urandom);
        blks[0] = rand128();
        build_exp(base, 1);
        do_start(base, 13'd1, sc);
        feed(1, 1'b1, 1'b0);
        wait_done();
        total++; if (wa_q.size() != 4 || done_cnt != 1) begin bad++; $display("[TB] FAIL mid_fresh got=%0d/%0d exp=4/1", wa_q.size(), done_cnt); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
                bad++;
                $display("[TB] FAIL mid_word%0d got=%h@%h exp=%h@%h", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        num_blocks = '0;
        blk_data   = '0;
        blk_valid  = 1'b0;
        clear_mon();
        test_reset();
        test_single();
        test_wrap();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
